// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle ARM-subset CPU: FSM state encoding,
// opcode values and datapath select codes used by control, decoder and datapath muxes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] REG_PC = 4'd15;

  // States that hold mem_req high and may stall on mem_ready.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs, memory handshake and datapath control outputs of
// the multicycle sequencer; master is the controller, slave is the datapath side.
interface multicycle_ctrl_if;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       no_write;
  logic       cond_ex;
  logic       mem_ready;

  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       instr_done;
  logic       bus_err;
  logic       illegal;

  modport master (
    input  op, funct, rd, no_write, cond_ex, mem_ready,
    output mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
           alu_src_a, alu_src_b, result_src, alu_op, instr_done, bus_err, illegal
  );

  modport slave (
    output op, funct, rd, no_write, cond_ex, mem_ready,
    input  mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
           alu_src_a, alu_src_b, result_src, alu_op, instr_done, bus_err, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait-state counter: cleared whenever no access is pending, counts
// stalled cycles, and flags expiry once WAIT_MAX stalls have been seen.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] count_r;

  // Stall counter; clear has priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + WAIT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and enables.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  state_e     state_r, state_nxt;
  logic       active_r;
  logic       in_wait_s, timeout_s, expired_s, tmr_clear_s, tmr_inc_s;

  logic       mem_req_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s, mem_write_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
  logic       alu_op_s, instr_done_s, bus_err_s, illegal_s;

  // Holds every output low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt;
    end
  end

  assign in_wait_s   = active_r && is_mem_wait(state_r);
  assign timeout_s   = in_wait_s && !bus.mem_ready && expired_s;
  assign tmr_clear_s = !in_wait_s || bus.mem_ready || timeout_s;
  assign tmr_inc_s   = in_wait_s && !bus.mem_ready;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_s),
    .inc     (tmr_inc_s),
    .expired (expired_s)
  );

  // Next-state and per-state output decode.
  always_comb begin
    state_nxt    = state_r;
    mem_req_s    = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_a_s  = SRCA_RN;
    alu_src_b_s  = SRCB_RM;
    result_src_s = RES_ALUOUT;
    alu_op_s     = 1'b0;
    instr_done_s = 1'b0;
    bus_err_s    = 1'b0;
    illegal_s    = 1'b0;

    if (!active_r) begin
      state_nxt = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req_s    = 1'b1;
          alu_src_a_s  = SRCA_PC;
          alu_src_b_s  = SRCB_FOUR;
          result_src_s = RES_ALU;
          if (timeout_s) begin
            // Abort without advancing PC; the fetch is retried from scratch.
            bus_err_s    = 1'b1;
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else if (bus.mem_ready) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_nxt  = S_DECODE;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_a_s = SRCA_PC;
          alu_src_b_s = SRCB_FOUR;
          if (bus.op == OP_ILL) begin
            illegal_s    = 1'b1;
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else if (!bus.cond_ex) begin
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else begin
            case (bus.op)
              OP_MEM:  state_nxt = S_MEMADR;
              OP_BR:   state_nxt = S_BRANCH;
              OP_DP:   state_nxt = bus.funct[5] ? S_EXECI : S_EXECR;
              default: state_nxt = S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a_s = SRCA_RN;
          alu_src_b_s = SRCB_IMM;
          state_nxt   = bus.funct[0] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req_s = 1'b1;
          adr_src_s = 1'b1;
          if (timeout_s) begin
            bus_err_s    = 1'b1;
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else if (bus.mem_ready) begin
            state_nxt = S_MEMWB;
          end else begin
            state_nxt = S_MEMRD;
          end
        end
        S_MEMWB: begin
          result_src_s = RES_DATA;
          instr_done_s = 1'b1;
          if (bus.rd == REG_PC) begin
            pc_write_s = 1'b1;
          end else begin
            reg_write_s = 1'b1;
          end
          state_nxt = S_FETCH;
        end
        S_MEMWR: begin
          mem_req_s   = 1'b1;
          mem_write_s = 1'b1;
          adr_src_s   = 1'b1;
          if (timeout_s) begin
            bus_err_s    = 1'b1;
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else if (bus.mem_ready) begin
            instr_done_s = 1'b1;
            state_nxt    = S_FETCH;
          end else begin
            state_nxt = S_MEMWR;
          end
        end
        S_EXECR: begin
          alu_src_a_s = SRCA_RN;
          alu_src_b_s = SRCB_RM;
          alu_op_s    = 1'b1;
          state_nxt   = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a_s = SRCA_RN;
          alu_src_b_s = SRCB_IMM;
          alu_op_s    = 1'b1;
          state_nxt   = S_ALUWB;
        end
        S_ALUWB: begin
          result_src_s = RES_ALUOUT;
          instr_done_s = 1'b1;
          if (bus.no_write) begin
            state_nxt = S_FETCH;
          end else if (bus.rd == REG_PC) begin
            pc_write_s = 1'b1;
          end else begin
            reg_write_s = 1'b1;
          end
          state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a_s  = SRCA_ALUOUT;
          alu_src_b_s  = SRCB_IMM;
          result_src_s = RES_ALU;
          pc_write_s   = 1'b1;
          instr_done_s = 1'b1;
          state_nxt    = S_FETCH;
        end
        default: begin
          state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_s;
  assign bus.adr_src    = adr_src_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.result_src = result_src_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.instr_done = instr_done_s;
  assign bus.bus_err    = bus_err_s;
  assign bus.illegal    = illegal_s;

endmodule
